// File: rtl/ex_stage.sv
// Execute stage: ALU control decode, operand forwarding and the EX/MEM
// result register with a valid/ready handshake toward MEM.
module ex_stage #(
    parameter int DW = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [1:0]    alu_op_i,
    input  logic [3:0]    funct_i,
    input  logic          alu_src_i,
    input  logic [DW-1:0] rs1_data_i,
    input  logic [DW-1:0] rs2_data_i,
    input  logic [DW-1:0] imm_i,
    input  logic [4:0]    rs1_addr_i,
    input  logic [4:0]    rs2_addr_i,
    input  logic [4:0]    rd_addr_i,
    input  logic          reg_write_i,
    input  logic          flush_i,
    input  logic          mem_fwd_en_i,
    input  logic          wb_fwd_en_i,
    input  logic [4:0]    mem_fwd_rd_i,
    input  logic [4:0]    wb_fwd_rd_i,
    input  logic [DW-1:0] mem_fwd_data_i,
    input  logic [DW-1:0] wb_fwd_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_result_o,
    output logic          out_zero_o,
    output logic [4:0]    out_rd_o,
    output logic          out_reg_write_o,
    output logic [7:0]    illegal_cnt_o
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_ILL = 4'b1111;

    logic [3:0]    ctrl;
    logic          illegal;
    logic [DW-1:0] fwd1;
    logic [DW-1:0] fwd2;
    logic [DW-1:0] src2;
    logic [DW-1:0] diff;
    logic [DW-1:0] alu_res;
    logic          accept;

    logic          valid_q, valid_d;
    logic [DW-1:0] result_q, result_d;
    logic          zero_q, zero_d;
    logic [4:0]    rd_q, rd_d;
    logic          we_q, we_d;
    logic [7:0]    cnt_q, cnt_d;

    always_comb begin
        ctrl = CTRL_ILL;
        case (alu_op_i)
            2'b00: ctrl = CTRL_ADD;
            2'b01: ctrl = CTRL_SUB;
            2'b10: begin
                case (funct_i)
                    4'b0000: ctrl = CTRL_ADD;
                    4'b1000: ctrl = CTRL_SUB;
                    4'b0111: ctrl = CTRL_AND;
                    4'b0110: ctrl = CTRL_OR;
                    4'b0010: ctrl = CTRL_SLT;
                    default: ctrl = CTRL_ILL;
                endcase
            end
            default: begin
                // funct7 bit is meaningless for I-type, only funct3 decodes
                case (funct_i[2:0])
                    3'b000:  ctrl = CTRL_ADD;
                    3'b111:  ctrl = CTRL_AND;
                    3'b110:  ctrl = CTRL_OR;
                    3'b010:  ctrl = CTRL_SLT;
                    default: ctrl = CTRL_ILL;
                endcase
            end
        endcase
    end

    assign illegal = (ctrl == CTRL_ILL);

    // MEM is younger than WB, so it wins; x0 is never forwarded
    always_comb begin
        fwd1 = rs1_data_i;
        if (mem_fwd_en_i && mem_fwd_rd_i == rs1_addr_i && rs1_addr_i != 5'd0)
            fwd1 = mem_fwd_data_i;
        else if (wb_fwd_en_i && wb_fwd_rd_i == rs1_addr_i && rs1_addr_i != 5'd0)
            fwd1 = wb_fwd_data_i;
    end

    always_comb begin
        fwd2 = rs2_data_i;
        if (mem_fwd_en_i && mem_fwd_rd_i == rs2_addr_i && rs2_addr_i != 5'd0)
            fwd2 = mem_fwd_data_i;
        else if (wb_fwd_en_i && wb_fwd_rd_i == rs2_addr_i && rs2_addr_i != 5'd0)
            fwd2 = wb_fwd_data_i;
    end

    assign src2 = alu_src_i ? imm_i : fwd2;
    assign diff = fwd1 - src2;

    always_comb begin
        alu_res = {{(DW-1){1'b0}}, 1'b1};
        case (ctrl)
            CTRL_AND: alu_res = fwd1 & src2;
            CTRL_OR:  alu_res = fwd1 | src2;
            CTRL_ADD: alu_res = fwd1 + src2;
            CTRL_SUB: alu_res = diff;
            CTRL_SLT: alu_res = {{(DW-1){1'b0}}, diff[DW-1]};
            default:  alu_res = {{(DW-1){1'b0}}, 1'b1};
        endcase
    end

    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        rd_d     = rd_q;
        we_d     = we_q;
        if (flush_i) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            rd_d     = rd_addr_i;
            we_d     = reg_write_i && !illegal;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && illegal && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            rd_q     <= 5'd0;
            we_q     <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid_o     = valid_q;
    assign out_result_o    = result_q;
    assign out_zero_o      = zero_q;
    assign out_rd_o        = rd_q;
    assign out_reg_write_o = we_q;
    assign illegal_cnt_o   = cnt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: decode, forwarding, handshake,
// flush, illegal counting and reset.
module tb_ex_stage;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    alu_op;
    logic [3:0]    funct;
    logic          alu_src;
    logic [DW-1:0] rs1_data, rs2_data, imm;
    logic [4:0]    rs1_addr, rs2_addr, rd_addr;
    logic          reg_write;
    logic          flush;
    logic          mem_en, wb_en;
    logic [4:0]    mem_rd, wb_rd;
    logic [DW-1:0] mem_data, wb_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_zero;
    logic [4:0]    out_rd;
    logic          out_we;
    logic [7:0]    ill_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_stage #(.DW(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .alu_op_i(alu_op), .funct_i(funct), .alu_src_i(alu_src),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr),
        .reg_write_i(reg_write), .flush_i(flush),
        .mem_fwd_en_i(mem_en), .wb_fwd_en_i(wb_en),
        .mem_fwd_rd_i(mem_rd), .wb_fwd_rd_i(wb_rd),
        .mem_fwd_data_i(mem_data), .wb_fwd_data_i(wb_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_result_o(out_result), .out_zero_o(out_zero),
        .out_rd_o(out_rd), .out_reg_write_o(out_we),
        .illegal_cnt_o(ill_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [3:0] fn,
                          input logic src, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] im,
                          input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] rd, input logic we);
        in_valid  = 1'b1;
        alu_op    = op;
        funct     = fn;
        alu_src   = src;
        rs1_data  = a;
        rs2_data  = b;
        imm       = im;
        rs1_addr  = a1;
        rs2_addr  = a2;
        rd_addr   = rd;
        reg_write = we;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_result"}, out_result, 64'd0);
        check({tag, "_zero"}, 64'(out_zero), 64'd1);
        check({tag, "_rd"}, 64'(out_rd), 64'd0);
        check({tag, "_we"}, 64'(out_we), 64'd0);
        check({tag, "_cnt"}, 64'(ill_cnt), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 4'd0;
        alu_src = 1'b0; rs1_data = '0; rs2_data = '0; imm = '0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
        reg_write = 1'b0; flush = 1'b0; mem_en = 1'b0; wb_en = 1'b0;
        mem_rd = 5'd0; wb_rd = 5'd0; mem_data = '0; wb_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check_reset("rst0");
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // R-type sub then slt, 5 - 7
        out_ready = 1'b1;
        set_op(2'b10, 4'b1000, 1'b0, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd9, 1'b1);
        tick();
        check("sub_res", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_zero", 64'(out_zero), 64'd0);
        check("sub_valid", 64'(out_valid), 64'd1);
        check("sub_rd", 64'(out_rd), 64'd9);
        check("sub_we", 64'(out_we), 64'd1);
        set_op(2'b10, 4'b0010, 1'b0, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd9, 1'b1);
        tick();
        check("slt_res", out_result, 64'd1);
        set_op(2'b10, 4'b0111, 1'b0, 64'hC, 64'hA, 64'd0, 5'd1, 5'd2, 5'd4, 1'b1);
        tick();
        check("and_res", out_result, 64'h8);
        set_op(2'b10, 4'b0110, 1'b0, 64'hC, 64'hA, 64'd0, 5'd1, 5'd2, 5'd4, 1'b1);
        tick();
        check("or_res", out_result, 64'hE);
        set_op(2'b11, 4'b1111, 1'b1, 64'hFF, 64'h0, 64'h0F, 5'd1, 5'd2, 5'd4, 1'b0);
        tick();
        check("andi_res", out_result, 64'h0F);
        check("andi_we", 64'(out_we), 64'd0);
        set_op(2'b11, 4'b0000, 1'b1, 64'd5, 64'd0, -64'sd5, 5'd1, 5'd2, 5'd4, 1'b1);
        tick();
        check("addi_zero_res", out_result, 64'd0);
        check("addi_zero_flag", 64'(out_zero), 64'd1);
        set_op(2'b01, 4'b0101, 1'b0, 64'd3, 64'd3, 64'd0, 5'd1, 5'd2, 5'd4, 1'b0);
        tick();
        check("beq_sub_zero", 64'(out_zero), 64'd1);
        check("beq_cnt", 64'(ill_cnt), 64'd0);

        // forwarding priority and x0 exclusion
        mem_en = 1'b1; mem_rd = 5'd3; mem_data = 64'h10;
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'h20;
        set_op(2'b00, 4'd0, 1'b1, 64'h100, 64'd0, 64'd1, 5'd3, 5'd0, 5'd5, 1'b1);
        tick();
        check("fwd_mem", out_result, 64'h11);
        mem_en = 1'b0;
        tick();
        check("fwd_wb", out_result, 64'h21);
        mem_en = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
        set_op(2'b00, 4'd0, 1'b1, 64'h100, 64'd0, 64'd1, 5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        check("fwd_x0", out_result, 64'h101);
        mem_en = 1'b0; wb_rd = 5'd4;
        set_op(2'b10, 4'b0000, 1'b0, 64'd1, 64'h999, 64'd0, 5'd0, 5'd4, 5'd5, 1'b1);
        tick();
        check("fwd_rs2_wb", out_result, 64'h21);
        wb_en = 1'b0;

        // backpressure then release with a new op, no bubble
        set_op(2'b00, 4'd0, 1'b1, 64'h40, 64'd0, 64'd2, 5'd1, 5'd0, 5'd6, 1'b1);
        tick();
        check("bp_first", out_result, 64'h42);
        out_ready = 1'b0;
        set_op(2'b00, 4'd0, 1'b1, 64'h50, 64'd0, 64'd2, 5'd1, 5'd0, 5'd7, 1'b1);
        #1;
        check("bp_ready_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_res", out_result, 64'h42);
            check("bp_hold_rd", 64'(out_rd), 64'd6);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_rel", 64'(in_ready), 64'd1);
        tick();
        check("bp_new_res", out_result, 64'h52);
        check("bp_new_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);

        // illegal op
        set_op(2'b10, 4'b0101, 1'b0, 64'd8, 64'd9, 64'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        check("ill_res", out_result, 64'd1);
        check("ill_we", 64'(out_we), 64'd0);
        check("ill_cnt1", 64'(ill_cnt), 64'd1);

        // flush while holding; illegal op on input must not count
        set_op(2'b00, 4'd0, 1'b1, 64'd1, 64'd0, 64'd1, 5'd1, 5'd0, 5'd8, 1'b1);
        tick();
        out_ready = 1'b0;
        set_op(2'b10, 4'b0101, 1'b0, 64'd8, 64'd9, 64'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        check("fl_pre_valid", 64'(out_valid), 64'd1);
        check("fl_pre_we", 64'(out_we), 64'd1);
        flush = 1'b1;
        tick();
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_we", 64'(out_we), 64'd0);
        check("fl_cnt", 64'(ill_cnt), 64'd1);
        flush = 1'b0;
        out_ready = 1'b1;

        // saturation: 300 more illegal accepts
        for (int i = 0; i < 300; i++) tick();
        check("ill_sat", 64'(ill_cnt), 64'd255);

        // reset while holding
        set_op(2'b00, 4'd0, 1'b1, 64'h7, 64'd0, 64'd1, 5'd1, 5'd0, 5'd10, 1'b1);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rh_valid", 64'(out_valid), 64'd1);
        check("rh_res", out_result, 64'h8);
        rst = 1'b1;
        tick();
        check_reset("rst1");
        rst = 1'b0;
        #1;
        check("ready_after_rst1", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
